cond_negate_pipe: RTL
=====================

// Module: cond_negate_pipe
// PURPOSE
//  Parametrised, pipelined conditional-negation unit; successor to the fixed 34-bit sign-XOR stage.
//  Converts LANES packed operands per beat: bypass, one's complement, two's complement, or absolute value.
//  Completes negation in-block (+1 carry), flags overflow, and supports valid/ready backpressure.
//  Sits between the MAC accumulators and the output quantiser in the TPU datapath.
// PARAMETERS
//  WIDTH     34  bits per lane operand/result
//  LANES     4   operands per beat
//  SATURATE  1   1: overflowed lanes output MAX (0111..1); 0: wrap (output MIN = 1000..0)
//  CNT_W     16  width of overflow-event counter
// PORTS
//  clk        in   1              clock, all state on rising edge
//  rst        in   1              asynchronous, active-high reset
//  mode       in   2              per-beat op, sampled with in_valid&in_ready: 0 BYPASS, 1 ONES, 2 TWOS, 3 ABS
//  in_valid   in   1              input beat valid
//  in_ready   out  1              input accepted when in_valid&in_ready
//  in_data    in   LANES*WIDTH    lane i = in_data[i*WIDTH +: WIDTH]
//  in_sign    in   LANES          per-lane negate request (ONES/TWOS modes)
//  out_valid  out  1              result beat valid
//  out_ready  in   1              downstream accepts when out_valid&out_ready
//  out_data   out  LANES*WIDTH    results, same packing as in_data
//  out_ovf    out  LANES          per-lane overflow flag, qualified by out_valid
//  ovf_cnt    out  CNT_W          count of delivered beats with any out_ovf bit set
//  cnt_clr    in   1              synchronous clear of ovf_cnt
// BEHAVIOUR
//  - Reset: s1/s2 valid=0, all data/flag regs=0; out_valid=0, out_data=0, out_ovf=0, ovf_cnt=0; in_ready=0 while rst high.
//  - Two register stages, latency 2 cycles with no stall, throughput 1 beat/cycle.
//  - Flow: s2_en = !s2_valid | out_ready; s1_en = !s1_valid | s2_en; in_ready = s1_en & !rst. No bubble on full-rate stream.
//  - Stalled stage holds data/flags stable; out_data/out_ovf stable while out_valid & !out_ready.
//  - Stage 1 per lane: neg = (mode==ONES|TWOS) ? in_sign[i] : (mode==ABS) ? in_data_i[WIDTH-1] : 0.
//    x = in_data_i ^ {WIDTH{neg}}; cin = neg & (mode!=ONES); ovf = cin & (in_data_i == MIN). Register x, cin, ovf.
//  - Stage 2 per lane: sum = x + cin (WIDTH bits, carry-out dropped); out = (ovf & SATURATE) ? MAX : sum.
//  - ONES never flags ovf. BYPASS: out = in, ovf = 0. Negating 0 in TWOS/ABS gives 0, no ovf.
//  - Mode is per beat: consecutive beats with different modes convert independently, no flush needed.
//  - ovf_cnt: +1 on each out_valid&out_ready beat with |out_ovf; saturates at all-ones; cnt_clr wins over increment.
//  - Reset asserted mid-stream: in-flight beats discarded, no output produced for them.
// STRUCTURE
//  - Package cond_negate_pkg: mode localparams MODE_BYPASS/ONES/TWOS/ABS (2-bit), MIN/MAX helpers of WIDTH.
//  - Sub-module cond_negate_lane: one lane's stage-1 combinational logic (neg, x, cin, ovf);
//    instantiated LANES times by generate. Top owns pipeline registers, handshake, and counter.
// TESTING (bench instance WIDTH=8, LANES=2, SATURATE=1)
//  - TWOS, data {0x05,0x05}, sign 2'b01 -> lane0 0xFB, lane1 0x05, ovf 0, out_valid 2 cycles after accept.
//  - ABS, data {0x80,0xFF} -> lane0 0x01, lane1 0x7F (saturated), out_ovf 2'b10, ovf_cnt 1; repeat SATURATE=0 -> lane1 0x80.
//  - ONES, data {0x00,0x80}, sign 2'b11 -> {0xFF,0x7F}, ovf 0; BYPASS with sign 2'b11 -> data unchanged.
//  - Stream 8 beats at full rate, out_ready low 3 cycles mid-stream -> in_ready drops after 2 held beats, no loss/dup, order kept.
//  - Alternate modes every beat (BYPASS,TWOS,ABS,ONES) on 0x80 -> 0x80, 0x7F ovf, 0x7F ovf, 0x7F.
//  - Assert rst with 2 beats in flight -> out_valid 0 next edge, ovf_cnt 0; cnt_clr with ovf beat same cycle -> ovf_cnt 0.

Source files
------------

// File: rtl/cond_negate_pkg.sv
// Shared definitions for the conditional-negation pipeline: op modes and
// WIDTH-dependent MIN/MAX constant helpers.
package cond_negate_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_ONES   = 2'd1,
      MODE_TWOS   = 2'd2,
      MODE_ABS    = 2'd3
   } mode_e;

   localparam int unsigned        MAX_WIDTH = 64;
   localparam logic [MAX_WIDTH-1:0] ONE_W   = {{(MAX_WIDTH-1){1'b0}}, 1'b1};

   // Helpers return MAX_WIDTH-bit values; callers truncate to their WIDTH.
   function automatic logic [MAX_WIDTH-1:0] min_val(input int unsigned w);
      return ONE_W << (w - 1);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] max_val(input int unsigned w);
      return min_val(w) - ONE_W;
   endfunction

endpackage

// File: rtl/cond_negate_lane.sv
// Stage-1 logic for one lane: decides negation, inverts the operand and
// produces the deferred +1 carry and the MIN-negation overflow flag.
module cond_negate_lane
   import cond_negate_pkg::*;
#(
   parameter int unsigned WIDTH = 34
) (
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] data,
   input  logic             sign,
   output logic [WIDTH-1:0] x,
   output logic             cin,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MIN = WIDTH'(min_val(WIDTH));

   logic neg;

   always_comb begin
      neg = 1'b0;
      case (mode)
         MODE_ONES, MODE_TWOS: neg = sign;
         MODE_ABS:             neg = data[WIDTH-1];
         default:              neg = 1'b0;
      endcase
      x   = data ^ {WIDTH{neg}};
      cin = neg & (mode != MODE_ONES);
      ovf = cin & (data == MIN);
   end

endmodule

// File: rtl/cond_negate_pipe.sv
// Two-stage pipelined conditional negation over LANES packed operands with
// valid/ready backpressure, optional saturation and an overflow-beat counter.
module cond_negate_pipe
   import cond_negate_pkg::*;
#(
   parameter int unsigned WIDTH    = 34,
   parameter int unsigned LANES    = 4,
   parameter bit          SATURATE = 1'b1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             mode,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_data,
   input  logic [LANES-1:0]       in_sign,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]       out_ovf,
   output logic [CNT_W-1:0]       ovf_cnt,
   input  logic                   cnt_clr
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(max_val(WIDTH));

   logic [LANES*WIDTH-1:0] lane_x;
   logic [LANES-1:0]       lane_cin;
   logic [LANES-1:0]       lane_ovf;

   logic                   s1_valid;
   logic [LANES*WIDTH-1:0] s1_x;
   logic [LANES-1:0]       s1_cin;
   logic [LANES-1:0]       s1_ovf;

   logic                   s2_valid;
   logic [LANES*WIDTH-1:0] s2_data;
   logic [LANES-1:0]       s2_ovf;
   logic [LANES*WIDTH-1:0] s2_next;

   logic s1_en;
   logic s2_en;
   logic accept;

   always_comb begin
      s2_en    = !s2_valid | out_ready;
      s1_en    = !s1_valid | s2_en;
      in_ready = s1_en & !rst;
      accept   = in_valid & in_ready;
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      cond_negate_lane #(
         .WIDTH(WIDTH)
      ) u_lane (
         .mode (mode),
         .data (in_data[i*WIDTH +: WIDTH]),
         .sign (in_sign[i]),
         .x    (lane_x[i*WIDTH +: WIDTH]),
         .cin  (lane_cin[i]),
         .ovf  (lane_ovf[i])
      );
   end

   // Stage 2 completes the two's complement; carry-out of the +1 is dropped.
   always_comb begin
      s2_next = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (s1_ovf[i] && SATURATE)
            s2_next[i*WIDTH +: WIDTH] = MAX;
         else
            s2_next[i*WIDTH +: WIDTH] = s1_x[i*WIDTH +: WIDTH]
                                      + {{(WIDTH-1){1'b0}}, s1_cin[i]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_cin   <= '0;
         s1_ovf   <= '0;
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_ovf   <= '0;
      end else begin
         if (s1_en) begin
            s1_valid <= accept;
            if (accept) begin
               s1_x   <= lane_x;
               s1_cin <= lane_cin;
               s1_ovf <= lane_ovf;
            end
         end
         if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_data <= s2_next;
               s2_ovf  <= s1_ovf;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf_cnt <= '0;
      else if (cnt_clr)
         ovf_cnt <= '0;
      else if (s2_valid && out_ready && (|s2_ovf) && (ovf_cnt != '1))
         ovf_cnt <= ovf_cnt + 1'b1;
   end

   always_comb begin
      out_valid = s2_valid;
      out_data  = s2_data;
      out_ovf   = s2_ovf;
   end

endmodule
